// File: rtl/serial_2wire_arb_pkg.sv
// Shared types and helpers for serial bus sequencers.
//   arb_state_e : arbiter FSM states (IDLE / ACTIVE / DRAIN)
//   rr_next     : round-robin successor index, wraps at n
package serial_2wire_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/serial_2wire_arb_rr_select.sv
// Round-robin priority select.
//   req   : request vector
//   last  : index of the previous winner; search starts at last+1 (mod NUM_REQ)
//   valid : some request is pending
//   index : first pending requester found in search order
module rr_select
  import serial_2wire_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int unsigned cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 32'(last);
    // Visit every requester exactly once, last+1 first, last itself at the end.
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_next(cand, NUM_REQ);
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/serial_2wire_arb.sv
// Arbiter sharing one serial 2-wire master among NUM_REQ requesters.
//   in_clk / in_rst          : clock, async active-high reset
//   in_req/in_addr/in_data   : per-requester level request, device address, data word
//   out_grant                : one-hot grant (held through ACTIVE and DRAIN)
//   out_next_word / out_err  : per-requester 1-cycle pulses forwarded from the master
//   out_ser_*                : muxed request to the master, enable only in ACTIVE
//   in_ser_ready/next/error  : master idle / word latched / NACK
//   out_busy                 : arbiter not idle
module serial_2wire_arb
  import serial_2wire_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SERIAL_BITS = 8,
  parameter int ADDR_BITS   = 7,
  parameter int MAX_WORDS   = 16
) (
  input  logic                                 in_clk,
  input  logic                                 in_rst,
  input  logic [NUM_REQ-1:0]                   in_req,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]    in_addr,
  input  logic [NUM_REQ-1:0][SERIAL_BITS-1:0]  in_data,
  output logic [NUM_REQ-1:0]                   out_grant,
  output logic [NUM_REQ-1:0]                   out_next_word,
  output logic [NUM_REQ-1:0]                   out_err,
  output logic                                 out_ser_enable,
  output logic [ADDR_BITS-1:0]                 out_ser_addr,
  output logic [SERIAL_BITS-1:0]               out_ser_data,
  input  logic                                 in_ser_ready,
  input  logic                                 in_ser_next,
  input  logic                                 in_ser_error,
  output logic                                 out_busy
);

  localparam int IW     = $clog2(NUM_REQ);
  localparam int CW_RAW = $clog2(MAX_WORDS + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  arb_state_e           state, state_nxt;
  logic [IW-1:0]        winner, last_winner, rr_idx;
  logic                 rr_vld;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [NUM_REQ-1:0]   win_oh;
  logic                 other_pend, limit_hit;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IW)) u_rr (
    .req   (in_req),
    .last  (last_winner),
    .valid (rr_vld),
    .index (rr_idx)
  );

  assign win_oh     = NUM_REQ'(1) << winner;
  assign other_pend = |(in_req & ~win_oh);

  // Count including this cycle's word, so the release happens on the word
  // that reaches the limit rather than one word late. Saturates at MAX_WORDS.
  always_comb begin
    cnt_nxt = cnt;
    if (MAX_WORDS > 0 && state == ACTIVE && in_ser_next && cnt != MAX_CNT)
      cnt_nxt = cnt + CW'(1);
  end

  assign limit_hit = (MAX_WORDS > 0) && (cnt_nxt == MAX_CNT) && other_pend;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state       <= IDLE;
      winner      <= '0;
      last_winner <= IW'(NUM_REQ - 1);
      cnt         <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == ACTIVE) begin
        winner <= rr_idx;
        cnt    <= '0;
      end else if (state == DRAIN && state_nxt == IDLE) begin
        last_winner <= winner;
        cnt         <= '0;
      end else if (state == ACTIVE) begin
        cnt <= cnt_nxt;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    out_busy       = (state != IDLE);
    out_grant      = '0;
    out_ser_enable = 1'b0;
    out_ser_addr   = '0;
    out_ser_data   = '0;
    out_next_word  = '0;
    out_err        = '0;
    case (state)
      IDLE: begin
        if (rr_vld && in_ser_ready) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        out_grant      = win_oh;
        out_ser_enable = 1'b1;
        out_ser_addr   = in_addr[winner];
        out_ser_data   = in_data[winner];
        if (in_ser_next)  out_next_word = win_oh;
        if (in_ser_error) out_err       = win_oh;
        if (in_ser_error || !in_req[winner] || limit_hit) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_grant = win_oh;
        if (in_ser_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_2wire_arb.sv
module tb_serial_2wire_arb;

  logic            in_clk = 1'b0;
  logic            in_rst = 1'b1;
  logic [1:0]      in_req = '0;
  logic [1:0][6:0] in_addr;
  logic [1:0][7:0] in_data;
  logic [1:0]      out_grant, out_next_word, out_err;
  logic            out_ser_enable, out_busy;
  logic [6:0]      out_ser_addr;
  logic [7:0]      out_ser_data;
  logic            in_ser_ready = 1'b0, in_ser_next = 1'b0, in_ser_error = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  serial_2wire_arb #(.NUM_REQ(2), .SERIAL_BITS(8), .ADDR_BITS(7), .MAX_WORDS(4)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req), .in_addr(in_addr), .in_data(in_data),
    .out_grant(out_grant), .out_next_word(out_next_word), .out_err(out_err),
    .out_ser_enable(out_ser_enable), .out_ser_addr(out_ser_addr), .out_ser_data(out_ser_data),
    .in_ser_ready(in_ser_ready), .in_ser_next(in_ser_next), .in_ser_error(in_ser_error),
    .out_busy(out_busy)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [1:0] req;
    logic       rdy, nxt, err;
    logic [1:0] e_gnt;
    logic       e_en;
    logic [1:0] e_nw, e_err;
    logic       e_busy;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic [1:0] r, logic rd, logic nx, logic er, logic [1:0] g,
                              logic en, logic [1:0] nw, logic [1:0] e, logic b, logic [7:0] d);
    vec_t v;
    v.req = r; v.rdy = rd; v.nxt = nx; v.err = er;
    v.e_gnt = g; v.e_en = en; v.e_nw = nw; v.e_err = e; v.e_busy = b; v.e_data = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive inputs just after the falling edge, sample outputs 1 time unit later.
  task automatic step(input logic [1:0] r, input logic rd, input logic nx, input logic er);
    @(negedge in_clk);
    in_req = r; in_ser_ready = rd; in_ser_next = nx; in_ser_error = er;
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    int w;
    in_addr[0] = 7'h11; in_addr[1] = 7'h22;
    in_data[0] = 8'hA5; in_data[1] = 8'h3C;

    //         req   rdy nxt err  gnt   en nw    err   busy data
    tbl[0]  = mk(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
    tbl[1]  = mk(2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00); // master busy: no grant
    tbl[2]  = mk(2'b11, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
    tbl[3]  = mk(2'b11, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 8'hA5); // requester 0 wins first
    tbl[4]  = mk(2'b11, 0, 1, 0, 2'b01, 1, 2'b01, 2'b00, 1, 8'hA5);
    tbl[5]  = mk(2'b11, 0, 1, 0, 2'b01, 1, 2'b01, 2'b00, 1, 8'hA5);
    tbl[6]  = mk(2'b11, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 8'hA5);
    tbl[7]  = mk(2'b11, 0, 1, 0, 2'b01, 1, 2'b01, 2'b00, 1, 8'hA5);
    tbl[8]  = mk(2'b10, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 8'hA5); // req0 drops
    tbl[9]  = mk(2'b10, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 8'h00); // DRAIN
    tbl[10] = mk(2'b10, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 8'h00);
    tbl[11] = mk(2'b10, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 8'h00);
    tbl[12] = mk(2'b10, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
    tbl[13] = mk(2'b10, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 1, 8'h3C);
    tbl[14] = mk(2'b10, 0, 1, 1, 2'b10, 1, 2'b10, 2'b10, 1, 8'h3C); // next+error together
    tbl[15] = mk(2'b10, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1, 8'h00);
    tbl[16] = mk(2'b10, 1, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1, 8'h00);
    tbl[17] = mk(2'b01, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
    tbl[18] = mk(2'b01, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);
    tbl[19] = mk(2'b01, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 8'hA5);
    tbl[20] = mk(2'b00, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 8'hA5);
    tbl[21] = mk(2'b00, 1, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 8'h00);
    tbl[22] = mk(2'b00, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 8'h00);

    // Reset state
    #12;
    chk("rst_grant", 32'(out_grant), 0);
    chk("rst_en",    32'(out_ser_enable), 0);
    chk("rst_busy",  32'(out_busy), 0);
    @(negedge in_clk);
    in_rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].req, tbl[i].rdy, tbl[i].nxt, tbl[i].err);
      chk($sformatf("v%0d_grant", i), 32'(out_grant), 32'(tbl[i].e_gnt));
      chk($sformatf("v%0d_en", i),    32'(out_ser_enable), 32'(tbl[i].e_en));
      chk($sformatf("v%0d_nw", i),    32'(out_next_word), 32'(tbl[i].e_nw));
      chk($sformatf("v%0d_err", i),   32'(out_err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_busy", i),  32'(out_busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_data", i),  32'(out_ser_data), 32'(tbl[i].e_data));
      if (tbl[i].e_en)
        chk($sformatf("v%0d_addr", i), 32'(out_ser_addr), (tbl[i].e_gnt == 2'b01) ? 32'h11 : 32'h22);
    end

    // Word limit: both requesting, grants alternate every 4 words from a fresh reset
    @(negedge in_clk); in_rst = 1'b1;
    @(negedge in_clk); in_rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      w = 0;
      do begin
        step(2'b11, 1, 0, 0);
        w++;
      end while (out_grant == 2'b00 && w < 6);
      chk($sformatf("alt%0d_grant", r), 32'(out_grant), 32'(exp_g));
      for (int k = 0; k < 4; k++) begin
        step(2'b11, 1, 1, 0);
        chk($sformatf("alt%0d_nw%0d", r, k), 32'(out_next_word), 32'(exp_g));
      end
      step(2'b11, 1, 0, 0);
      chk($sformatf("alt%0d_drain_en", r), 32'(out_ser_enable), 0);
      chk($sformatf("alt%0d_drain_grant", r), 32'(out_grant), 32'(exp_g));
    end

    // Reset in the middle of ACTIVE drops everything in the same cycle
    step(2'b11, 1, 0, 0);
    step(2'b11, 0, 1, 0);
    chk("pre_rst_grant", 32'(out_grant), 32'h2);
    in_rst = 1'b1;
    #1;
    chk("mid_rst_grant", 32'(out_grant), 0);
    chk("mid_rst_en",    32'(out_ser_enable), 0);
    chk("mid_rst_nw",    32'(out_next_word), 0);
    chk("mid_rst_busy",  32'(out_busy), 0);
    @(negedge in_clk); in_rst = 1'b0;
    step(2'b11, 1, 0, 0);
    chk("post_rst_idle", 32'(out_grant), 0);
    step(2'b11, 0, 0, 0);
    chk("post_rst_grant", 32'(out_grant), 32'h1);

    // Sole requester past the limit keeps the grant; a newcomer forces release
    for (int k = 0; k < 6; k++) begin
      step(2'b01, 0, 1, 0);
      chk($sformatf("sat%0d_grant", k), 32'(out_grant), 32'h1);
      chk($sformatf("sat%0d_nw", k), 32'(out_next_word), 32'h1);
    end
    step(2'b11, 0, 0, 0);
    chk("sat_still_en", 32'(out_ser_enable), 1);
    step(2'b11, 0, 0, 0);
    chk("sat_release_en",    32'(out_ser_enable), 0);
    chk("sat_release_grant", 32'(out_grant), 32'h1);
    chk("sat_release_busy",  32'(out_busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end

endmodule
